msrv32_integer_file: RTL
========================

# msrv32_integer_file

Integer register file of the msrv32 RV32I pipeline. It is the consumer of the integer-file write enable produced in the write-back stage, and it serves the two source-operand read ports to the decode/execute stage. It holds 31 general-purpose 32-bit registers, with x0 hardwired to zero. It commits one write per clock when the write enable is asserted.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- ADDR_W, 5, register address width (32 architectural registers).

Ports:
- ms_riscv32_mp_clk_in  input  1  single clock; all state updates on its rising edge.
- ms_riscv32_mp_rst_in  input  1  reset, synchronous, active-high.
- rs_1_addr_in  input  ADDR_W  source register 1 address.
- rs_2_addr_in  input  ADDR_W  source register 2 address.
- rd_addr_in  input  ADDR_W  destination register address, from the write-back stage.
- rd_in  input  XLEN  write-back data.
- wr_en_in  input  1  integer-file write enable; already gated by flush upstream.
- rs_1_out  output  XLEN  read data for rs_1_addr_in.
- rs_2_out  output  XLEN  read data for rs_2_addr_in.

## Operation
- Storage is registers x1..x31, XLEN bits each. x0 has no storage.
- Write:
  - On a rising edge with wr_en_in=1 and rd_addr_in≠0, reg[rd_addr_in] takes rd_in.
  - A write to x0 is silently discarded.
  - With wr_en_in=0 no register changes, whatever the values on rd_addr_in and rd_in.
- Read:
  - Combinational from the current storage.
  - Address 0 always returns 32'h0, including when a write to x0 is attempted in the same cycle.
- The two read ports are independent. Both may address the same register, and that register may also be the write target.
- Reset:
  - A rising edge with ms_riscv32_mp_rst_in=1 clears x1..x31 to 0.
  - Reset has priority over a simultaneous write; the write is lost.
  - Reset asserted mid-program, for example between two back-to-back writes, discards all prior contents and behaves identically to power-on reset.
- There is no flush input. Flush suppression is the upstream generator's job. This block must not second-guess wr_en_in.

## Timing
- Write latency is 1 cycle: data written at edge N is visible on rs_x_out after edge N, unless MSRV32_RF_BYPASS_EN is defined (see below).
- Read latency is 0 cycles, with a combinational path from address to data.
- Reset values:
  - All storage is 0.
  - rs_1_out and rs_2_out are therefore 0 during and after reset for any address.
- Same-cycle read of the register being written (wr_en_in=1, rd_addr_in=rs_x_addr_in≠0):
  - Without bypass, the old value is returned.
  - With bypass, rd_in is returned.
- Simultaneous reset and write: storage reads 0 after the edge.
- Bypass never applies while ms_riscv32_mp_rst_in=1. Outputs read 0 in that cycle.

## Configuration
- Macro: MSRV32_RF_BYPASS_EN.
- Defined: each read port forwards rd_in when all of the following hold:
  - wr_en_in=1;
  - rd_addr_in equals that port's address;
  - the address is ≠0;
  - reset is deasserted.
  - This gives write-first behaviour and removes the write-back→decode hazard.
- Undefined: each read port returns stored contents only (read-before-write). The pipeline must then tolerate the 1-cycle RAW window.
- Storage and reset behaviour are identical in both builds.

## Structure
- Shared package msrv32_pkg holds:
  - XLEN = 32;
  - ADDR_W = 5;
  - REG_ZERO = 5'd0;
  - a reg_addr_t typedef (ADDR_W bits) and a word_t typedef (XLEN bits), reused by the decoder and the write-back stage.
- One sub-module, msrv32_rf_read_port, is instantiated twice. It takes the port address, the storage array value, and the write-port signals. It implements the x0 force-to-zero and the macro-controlled bypass mux.
- The top level holds the storage array, the write decode and the reset clear.

## Test plan
- Reset, then read all 32 addresses on both ports → every read is 32'h0.
- Write x5=32'hDEADBEEF. Next cycle read rs_1=x5, rs_2=x0 → rs_1_out=32'hDEADBEEF, rs_2_out=0.
- wr_en_in=1, rd_addr_in=0, rd_in=32'hFFFFFFFF; read x0 on both ports the same and the next cycle → always 0.
- x7=32'h11111111 stored. Write x7=32'h22222222 while reading rs_1=rs_2=x7 in the same cycle:
  - bypass build → 32'h22222222;
  - non-bypass build → 32'h11111111;
  - next cycle → 32'h22222222 in both builds.
- Write x9=32'hA5A5A5A5 with wr_en_in=0 → x9 still reads 32'h0.
- x3=32'h12345678 stored. Assert reset in the same cycle as a write x3=32'hCAFEF00D → x3 reads 0 after the edge; x31 written before reset also reads 0.

Source files
------------

// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared msrv32 widths, register address and data word types
//
// Purpose : common constants and types for the integer register file, the
//           decoder and the write-back stage.
// Contents: XLEN, ADDR_W, REG_ZERO, reg_addr_t, word_t.
package msrv32_pkg;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : msrv32_pkg

// File: rtl/msrv32_rf_read_port.sv
// rtl/msrv32_rf_read_port.sv - one integer register file read port with x0 forcing and optional bypass
//
// Purpose : selects a register from the storage image, forces x0 to zero,
//           forces zero while reset is asserted and, when MSRV32_RF_BYPASS_EN
//           is defined, forwards the in-flight write-back data (write-first).
// Macro   : MSRV32_RF_BYPASS_EN - enables the write-back forwarding mux.
// Ports   :
//   rst_in      input   reset, active-high (outputs zero while asserted)
//   addr_in     input   ADDR_W  read address
//   regs_in     input   storage image, entries 1..2**ADDR_W-1
//   wr_en_in    input   write enable of the write port
//   rd_addr_in  input   ADDR_W  write address
//   rd_in       input   XLEN    write data
//   rs_out      output  XLEN    read data
module msrv32_rf_read_port
    import msrv32_pkg::*;
#(
    parameter int XLEN_P   = XLEN,
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                                   rst_in,
    input  logic [ADDR_W_P-1:0]                    addr_in,
    input  logic [(2**ADDR_W_P)-1:1][XLEN_P-1:0]   regs_in,
    input  logic                                   wr_en_in,
    input  logic [ADDR_W_P-1:0]                    rd_addr_in,
    input  logic [XLEN_P-1:0]                      rd_in,
    output logic [XLEN_P-1:0]                      rs_out
);

`ifdef MSRV32_RF_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic w_addr_zero;
    logic w_fwd_hit;

    assign w_addr_zero = (addr_in == ADDR_W_P'(REG_ZERO));
    assign w_fwd_hit   = BYPASS_EN && wr_en_in && (rd_addr_in == addr_in);

    // Reset and x0 take priority over forwarding, so a write aimed at x0 or
    // a write racing a reset can never leak onto the read data.
    always_comb begin
        rs_out = '0;
        if (rst_in || w_addr_zero) begin
            rs_out = '0;
        end else if (w_fwd_hit) begin
            rs_out = rd_in;
        end else begin
            rs_out = regs_in[addr_in];
        end
    end

endmodule : msrv32_rf_read_port

// File: rtl/msrv32_integer_file.sv
// rtl/msrv32_integer_file.sv - msrv32 RV32I integer register file, 2 read ports, 1 write port
//
// Purpose : holds x1..x31 (x0 is hardwired zero, no storage), commits one
//           write per clock from write-back, serves two combinational reads.
// Macro   : MSRV32_RF_BYPASS_EN - read ports forward rd_in on a same-cycle
//           write to the addressed register (write-first); undefined gives
//           read-before-write.
// Ports   :
//   ms_riscv32_mp_clk_in  input   clock, rising edge
//   ms_riscv32_mp_rst_in  input   synchronous active-high reset, clears x1..x31
//   rs_1_addr_in          input   ADDR_W  source register 1 address
//   rs_2_addr_in          input   ADDR_W  source register 2 address
//   rd_addr_in            input   ADDR_W  destination register address
//   rd_in                 input   XLEN    write-back data
//   wr_en_in              input   write enable (flush already applied upstream)
//   rs_1_out              output  XLEN    read data, port 1
//   rs_2_out              output  XLEN    read data, port 2
module msrv32_integer_file
    import msrv32_pkg::*;
#(
    parameter int XLEN   = msrv32_pkg::XLEN,
    parameter int ADDR_W = msrv32_pkg::ADDR_W
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_in,
    input  logic [ADDR_W-1:0] rs_1_addr_in,
    input  logic [ADDR_W-1:0] rs_2_addr_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    input  logic [XLEN-1:0]   rd_in,
    input  logic              wr_en_in,
    output logic [XLEN-1:0]   rs_1_out,
    output logic [XLEN-1:0]   rs_2_out
);

    localparam int NREG = 2**ADDR_W;

    logic [NREG-1:1][XLEN-1:0] r_regs;
    logic                      w_wr_commit;

    // wr_en_in is trusted as-is; only the x0 target is filtered here.
    assign w_wr_commit = wr_en_in && (rd_addr_in != ADDR_W'(REG_ZERO));

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_regs <= '0;
        end else if (w_wr_commit) begin
            r_regs[rd_addr_in] <= rd_in;
        end
    end

    msrv32_rf_read_port #(
        .XLEN_P   (XLEN),
        .ADDR_W_P (ADDR_W)
    ) u_read_port_1 (
        .rst_in     (ms_riscv32_mp_rst_in),
        .addr_in    (rs_1_addr_in),
        .regs_in    (r_regs),
        .wr_en_in   (wr_en_in),
        .rd_addr_in (rd_addr_in),
        .rd_in      (rd_in),
        .rs_out     (rs_1_out)
    );

    msrv32_rf_read_port #(
        .XLEN_P   (XLEN),
        .ADDR_W_P (ADDR_W)
    ) u_read_port_2 (
        .rst_in     (ms_riscv32_mp_rst_in),
        .addr_in    (rs_2_addr_in),
        .regs_in    (r_regs),
        .wr_en_in   (wr_en_in),
        .rd_addr_in (rd_addr_in),
        .rd_in      (rd_in),
        .rs_out     (rs_2_out)
    );

endmodule : msrv32_integer_file
